// File: rtl/delta_adc_pkg.sv
// Shared types and helpers for the multi-channel delta-modulation ADC.
package delta_adc_pkg;

   // Readout sequencer states
   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_SEND = 1'b1
   } rd_state_t;

   // Shortest frame the period counter supports; smaller requests are raised to this
   localparam int MIN_PERIOD = 2;

   // Bits needed to index n items, never less than one bit
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/delta_adc_multi_if.sv
// Result stream of the delta ADC: one channel on-count per valid/ready transfer.
interface delta_adc_multi_if
   import delta_adc_pkg::*;
#(
   parameter int W    = 16,
   parameter int N_CH = 4
) ();

   localparam int CW = clog2_min1(N_CH);

   logic [W-1:0]  res_data_o;
   logic [CW-1:0] res_chan_o;
   logic          res_valid_o;
   logic          res_ready_i;
   logic          res_last_o;

   // Producer side (the ADC core)
   modport master (
      output res_data_o,
      output res_chan_o,
      output res_valid_o,
      output res_last_o,
      input  res_ready_i
   );

   // Consumer side
   modport slave (
      input  res_data_o,
      input  res_chan_o,
      input  res_valid_o,
      input  res_last_o,
      output res_ready_i
   );

endinterface

// File: rtl/delta_adc_chan.sv
// One delta-modulation channel: comparator synchroniser, 1-bit feedback register,
// on-cycle counter and frame snapshot.
module delta_adc_chan #(
   parameter int W           = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   input  logic         i_comp,
   input  logic         i_frame_end,
   input  logic         i_snap_en,
   output logic         o_pwm,
   output logic [W-1:0] o_snap
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_pwm;
   logic [W-1:0]           r_cnt;
   logic [W-1:0]           r_snap;
   logic                   w_pwm;

   // Feedback is forced low whenever conversion is disabled
   assign w_pwm = r_pwm & i_en;

   // Bring the asynchronous comparator into the clock domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_comp};
      end
   end

   // Feedback register: the last synchroniser stage drives the external RC/DAC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pwm <= 1'b0;
      end else begin
         r_pwm <= r_sync[SYNC_STAGES-1];
      end
   end

   // Count enabled cycles with feedback high; restart at every frame end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!i_en || i_frame_end) begin
         r_cnt <= '0;
      end else if (w_pwm) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Capture the finished frame, including the bit of the frame-end cycle itself
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_snap <= '0;
      end else if (i_snap_en) begin
         r_snap <= r_cnt + W'(w_pwm);
      end
   end

   assign o_pwm  = w_pwm;
   assign o_snap = r_snap;

endmodule

// File: rtl/delta_adc_multi.sv
// N-channel delta-modulation ADC core. Holds the shared frame counter, latched
// period, frame strobe, overrun flag and the readout sequencer that streams the
// per-channel snapshots out one channel per transfer.
module delta_adc_multi
   import delta_adc_pkg::*;
#(
   parameter int W             = 16,
   parameter int N_CH          = 4,
   parameter int STROBE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en_i,
   input  logic [W-1:0]    Period_counter_val,
   input  logic [N_CH-1:0] Comparator_i,
   output logic [N_CH-1:0] PWM_O,
   output logic            ADC_valid_strb,
   output logic            overrun_o,
   input  logic            ovr_clear_i,
   delta_adc_multi_if.master res
);

   localparam int            CW       = clog2_min1(N_CH);
   localparam int            SW       = $clog2(STROBE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_CH - 1);

   // Raise too-short period requests to the shortest supported frame
   function automatic logic [W-1:0] clamp_period(input logic [W-1:0] p);
      if (p < W'(MIN_PERIOD)) begin
         return W'(MIN_PERIOD);
      end
      return p;
   endfunction

   logic [W-1:0]  r_pcnt;
   logic [W-1:0]  r_plat;
   logic          r_active;
   logic [SW-1:0] r_strb_cnt;
   logic          r_ovr;
   rd_state_t     r_state;
   logic [CW-1:0] r_idx;

   logic [W-1:0]  w_period_in;
   logic [W-1:0]  w_plat;
   logic          w_frame_end;
   logic          w_hs;
   logic          w_last_idx;
   logic          w_accept;
   logic          w_ovr_set;
   rd_state_t     w_state_nxt;
   logic [CW-1:0] w_idx_nxt;
   logic [N_CH-1:0] w_pwm;
   logic [W-1:0]  w_snap [N_CH];

   assign w_period_in = clamp_period(Period_counter_val);
   // Outside a frame the live clamped input is the effective period, so the
   // first enabled cycle already uses the value that gets latched for it
   assign w_plat      = r_active ? r_plat : w_period_in;
   assign w_frame_end = en_i && (r_pcnt == (w_plat - 1'b1));

   // Frame counter and per-frame period latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pcnt   <= '0;
         r_plat   <= W'(MIN_PERIOD);
         r_active <= 1'b0;
      end else if (!en_i) begin
         r_pcnt   <= '0;
         r_active <= 1'b0;
      end else if (w_frame_end) begin
         r_pcnt   <= '0;
         r_plat   <= w_period_in;
         r_active <= 1'b1;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
         if (!r_active) begin
            r_plat   <= w_period_in;
            r_active <= 1'b1;
         end
      end
   end

   // Stretched frame-complete strobe; every frame end restarts the count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_strb_cnt <= '0;
      end else if (w_frame_end) begin
         r_strb_cnt <= SW'(STROBE_CYCLES);
      end else if (r_strb_cnt != '0) begin
         r_strb_cnt <= r_strb_cnt - 1'b1;
      end
   end

   assign ADC_valid_strb = (r_strb_cnt != '0);

   // Per-channel converters
   for (genvar c = 0; c < N_CH; c++) begin : g_chan
      delta_adc_chan #(
         .W           (W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .i_en        (en_i),
         .i_comp      (Comparator_i[c]),
         .i_frame_end (w_frame_end),
         .i_snap_en   (w_accept),
         .o_pwm       (w_pwm[c]),
         .o_snap      (w_snap[c])
      );
   end

   assign PWM_O = w_pwm;

   assign w_hs       = (r_state == RD_SEND) && res.res_ready_i;
   assign w_last_idx = (r_idx == LAST_IDX);

   // Readout sequencer: accept frames while idle or on the final handshake,
   // otherwise drop the new frame and flag an overrun
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_accept    = 1'b0;
      w_ovr_set   = 1'b0;
      case (r_state)
         RD_IDLE: begin
            if (w_frame_end) begin
               w_accept    = 1'b1;
               w_state_nxt = RD_SEND;
               w_idx_nxt   = '0;
            end
         end
         RD_SEND: begin
            if (w_hs) begin
               if (w_last_idx) begin
                  w_idx_nxt = '0;
                  if (w_frame_end) begin
                     w_accept    = 1'b1;
                     w_state_nxt = RD_SEND;
                  end else begin
                     w_state_nxt = RD_IDLE;
                  end
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
            if (w_frame_end && !(w_hs && w_last_idx)) begin
               w_ovr_set = 1'b1;
            end
         end
         default: begin
            w_state_nxt = RD_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Readout state and channel index registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RD_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Sticky overrun flag; a new overrun beats a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovr <= 1'b0;
      end else if (w_ovr_set) begin
         r_ovr <= 1'b1;
      end else if (ovr_clear_i) begin
         r_ovr <= 1'b0;
      end
   end

   assign overrun_o       = r_ovr;
   assign res.res_valid_o = (r_state == RD_SEND);
   assign res.res_chan_o  = r_idx;
   assign res.res_data_o  = w_snap[r_idx];
   assign res.res_last_o  = (r_state == RD_SEND) && w_last_idx;

endmodule
